// File: rtl/imem_pkg.sv
// Shared definitions for the instruction-memory loader: FSM encoding and frame field sizes.
package imem_pkg;

    // Loader FSM states.
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LEN   = 3'd1,
        S_DATA  = 3'd2,
        S_WRITE = 3'd3,
        S_CHK   = 3'd4,
        S_DONE  = 3'd5,
        S_ERR   = 3'd6
    } state_e;

    localparam int WORD_BYTES = 4;  // bytes per instruction word
    localparam int LEN_BYTES  = 4;  // little-endian word count header
    localparam int CHK_BYTES  = 1;  // trailing 8-bit additive checksum

endpackage

// File: rtl/imem_loader.sv
// Frame receiver that assembles a little-endian byte stream into 32-bit words
// and writes them into instruction memory with a one-cycle strobe.
//
// Handshake: a byte moves on a rising edge where i_Byte_Valid and o_Byte_Ready
// are both high. o_Byte_Ready depends on the registered state only, so the
// source may raise or drop i_Byte_Valid in any cycle without a timeout.
module imem_loader
    import imem_pkg::*;
#(
    parameter int          HEIGHT    = 256,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic        i_Clk,
    input  logic        i_Rst_n,
    input  logic        i_Start,
    input  logic [7:0]  i_Byte,
    input  logic        i_Byte_Valid,
    output logic        o_Byte_Ready,
    output logic        o_We,
    output logic [31:0] o_Waddr,
    output logic [31:0] o_Wdata,
    output logic        o_Busy,
    output logic        o_Done,
    output logic        o_Error,
    output state_e      o_Dbg_State
);

    // Largest word count that fits in the memory.
    localparam logic [31:0] MAX_WORDS = 32'(HEIGHT / WORD_BYTES);

    state_e      state_q, state_d;
    logic [31:0] len_q,   len_d;    // expected word count N
    logic [31:0] count_q, count_d;  // words written so far
    logic [31:0] addr_q,  addr_d;   // byte address of the word being assembled
    logic [31:0] word_q,  word_d;   // lane-select word assembler
    logic [1:0]  lane_q,  lane_d;   // byte index within LEN field or word
    logic [7:0]  sum_q,   sum_d;    // running mod-256 sum of LEN and payload bytes

    // Next-state logic: header shift, lane fill, word write and checksum decision.
    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        count_d = count_q;
        addr_d  = addr_q;
        word_d  = word_q;
        lane_d  = lane_q;
        sum_d   = sum_q;

        case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                if (i_Start) begin
                    state_d = S_LEN;
                    len_d   = '0;
                    count_d = '0;
                    addr_d  = BASE_ADDR;
                    word_d  = '0;
                    lane_d  = '0;
                    sum_d   = '0;
                end
            end

            S_LEN: begin
                if (i_Byte_Valid) begin
                    // Bytes arrive LSB first, so shift in from the top.
                    len_d  = {i_Byte, len_q[31:8]};
                    sum_d  = sum_q + i_Byte;
                    lane_d = lane_q + 2'd1;
                    if (lane_q == 2'(LEN_BYTES - 1)) begin
                        if (len_d > MAX_WORDS) begin
                            state_d = S_ERR;
                        end else if (len_d == 32'd0) begin
                            state_d = S_CHK;
                        end else begin
                            state_d = S_DATA;
                        end
                    end
                end
            end

            S_DATA: begin
                if (i_Byte_Valid) begin
                    case (lane_q)
                        2'd0:    word_d[7:0]   = i_Byte;
                        2'd1:    word_d[15:8]  = i_Byte;
                        2'd2:    word_d[23:16] = i_Byte;
                        default: word_d[31:24] = i_Byte;
                    endcase
                    sum_d  = sum_q + i_Byte;
                    lane_d = lane_q + 2'd1;
                    if (lane_q == 2'(WORD_BYTES - 1)) begin
                        state_d = S_WRITE;
                    end
                end
            end

            S_WRITE: begin
                // Strobe is decoded from this state; advance only if more words follow
                // so the address never walks past the last word of memory.
                count_d = count_q + 32'd1;
                if (count_d == len_q) begin
                    state_d = S_CHK;
                end else begin
                    addr_d  = addr_q + 32'(WORD_BYTES);
                    state_d = S_DATA;
                end
            end

            S_CHK: begin
                if (i_Byte_Valid) begin
                    state_d = (i_Byte == sum_q) ? S_DONE : S_ERR;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers with asynchronous active-low clear.
    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            state_q <= S_IDLE;
            len_q   <= '0;
            count_q <= '0;
            addr_q  <= '0;
            word_q  <= '0;
            lane_q  <= '0;
            sum_q   <= '0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            count_q <= count_d;
            addr_q  <= addr_d;
            word_q  <= word_d;
            lane_q  <= lane_d;
            sum_q   <= sum_d;
        end
    end

    // Outputs decode registered state only; no input reaches an output combinationally.
    assign o_Byte_Ready = (state_q == S_LEN) || (state_q == S_DATA) || (state_q == S_CHK);
    assign o_Busy       = o_Byte_Ready || (state_q == S_WRITE);
    assign o_We         = (state_q == S_WRITE);
    assign o_Waddr      = addr_q;
    assign o_Wdata      = word_q;
    assign o_Done       = (state_q == S_DONE);
    assign o_Error      = (state_q == S_ERR);
    assign o_Dbg_State  = state_q;

endmodule
